// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bundle. The EX stage drives requests
// and forwarded operands. The sequencer returns HI/LO, the read mux and the stall.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_req;
    logic        rd_sel;
    logic        flush_ex;
    logic [31:0] rd_data;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata, rd_req, rd_sel, flush_ex,
        input  rd_data, stall, busy, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata, rd_req, rd_sel, flush_ex,
        output rd_data, stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use 32 shift-add steps, and DIV/DIVU use 32 restoring-divide steps.
// Both work on operand magnitudes. Signs are fixed up in one final FIX cycle.
module muldiv_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    muldiv_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] acc_q;      // mul: {partial hi, shifted-in product}; div: {remainder, quotient}
    logic [31:0] opa_q;      // multiplier (shifts right) / dividend (shifts left)
    logic [31:0] opb_q;      // multiplicand / divisor magnitude
    logic [4:0]  count_q;
    logic        is_div_q;
    logic        neg_res_q;  // product or quotient needs negation
    logic        neg_rem_q;  // remainder takes the dividend's sign
    logic        dz_q;       // divide by zero: acc already holds the final HI/LO

    logic        start_eff;
    logic        mthi_eff;
    logic        mtlo_eff;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Decode requests from EX. Also form the operand magnitudes for a new op.
    always_comb begin
        start_eff = bus.start & ~bus.flush_ex;
        mthi_eff  = bus.mthi & ~bus.flush_ex;
        mtlo_eff  = bus.mtlo & ~bus.flush_ex;
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.src_a[31];
        b_neg     = signed_op & bus.src_b[31];
        // 0x80000000 negates to itself, which is the correct unsigned magnitude.
        mag_a     = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
        mag_b     = b_neg ? (32'd0 - bus.src_b) : bus.src_b;
        div_zero  = bus.op[1] & (bus.src_b == 32'd0);
    end

    // One iteration of multiply or divide. Also compute the FIX-cycle sign corrections.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (opa_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        rem_sh   = {acc_q[63:32], opa_q[31]};
        div_ge   = rem_sh >= {1'b0, opb_q};
        // A successful trial subtraction always leaves a result below the divisor.
        div_diff = rem_sh[31:0] - opb_q;
        div_next = {(div_ge ? div_diff : rem_sh[31:0]), acc_q[30:0], div_ge};

        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Sequencer FSM, iteration datapath and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            acc_q     <= 64'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            count_q   <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_eff) begin
                        opa_q     <= mag_a;
                        opb_q     <= mag_b;
                        is_div_q  <= bus.op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        count_q   <= 5'd0;
                        busy_q    <= 1'b1;
                        if (div_zero) begin
                            dz_q    <= 1'b1;
                            acc_q   <= {bus.src_a, 32'hFFFF_FFFF};
                            state_q <= StFix;
                        end else begin
                            dz_q    <= 1'b0;
                            acc_q   <= 64'd0;
                            state_q <= StRun;
                        end
                    end
                    if (mthi_eff) begin
                        hi_q <= bus.wdata;
                    end
                    if (mtlo_eff) begin
                        lo_q <= bus.wdata;
                    end
                end
                StRun: begin
                    if (is_div_q) begin
                        acc_q <= div_next;
                        opa_q <= {opa_q[30:0], 1'b0};
                    end else begin
                        acc_q <= mul_next;
                        opa_q <= {1'b0, opa_q[31:1]};
                    end
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (dz_q) begin
                        hi_q <= acc_q[63:32];
                        lo_q <= acc_q[31:0];
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs: registered HI/LO/busy, combinational read mux and stall.
    always_comb begin
        bus.hi      = hi_q;
        bus.lo      = lo_q;
        bus.busy    = busy_q;
        bus.rd_data = bus.rd_sel ? hi_q : lo_q;
        bus.stall   = busy_q & (bus.start | bus.rd_req | bus.mthi | bus.mtlo) & ~bus.flush_ex;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. A reference model produces the expected
// HI/LO and the busy length for each op. These go into a scoreboard queue
// when the op is driven. They are taken out and compared when busy drops.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_sequencer_if mif ();

    muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        e.cyc = 32'd33;
        p     = 64'd0;
        if (op == 2'b00) begin
            p = sa * sb;
        end else if (op == 2'b01) begin
            p = ua * ub;
        end else if (b == 32'd0) begin
            p     = {a, 32'hFFFF_FFFF};
            e.cyc = 32'd1;
        end else if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            p = {r[31:0], q[31:0]};
        end
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    task automatic idle_inputs();
        mif.start    = 1'b0;
        mif.op       = 2'b00;
        mif.src_a    = 32'd0;
        mif.src_b    = 32'd0;
        mif.mthi     = 1'b0;
        mif.mtlo     = 1'b0;
        mif.wdata    = 32'd0;
        mif.rd_req   = 1'b0;
        mif.rd_sel   = 1'b0;
        mif.flush_ex = 1'b0;
    endtask

    task automatic check_result(input string tag, input int n);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " busy cycles"}, n, e.cyc);
            check({tag, " hi"}, mif.hi, e.hi);
            check({tag, " lo"}, mif.lo, e.lo);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (mif.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_result(tag, n);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        sb_q.push_back(model(op, a, b));
        mif.start = 1'b1;
        mif.op    = op;
        mif.src_a = a;
        mif.src_b = b;
        step();
        mif.start = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bad;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("reset busy", mif.busy, 0);
        check("reset stall", mif.stall, 0);
        check("reset hi", mif.hi, 0);
        check("reset lo", mif.lo, 0);
        check("reset rd_data", mif.rd_data, 0);
        #12 rst_n = 1'b1;
        step();

        // MTLO / MTHI in IDLE; a flushed MTLO must not write.
        mif.mtlo  = 1'b1;
        mif.wdata = 32'h0000_1234;
        step();
        mif.mtlo = 1'b0;
        check("mtlo lo", mif.lo, 32'h1234);
        check("mtlo rd_data", mif.rd_data, 32'h1234);
        mif.mtlo     = 1'b1;
        mif.flush_ex = 1'b1;
        mif.wdata    = 32'hDEAD_BEEF;
        step();
        mif.mtlo     = 1'b0;
        mif.flush_ex = 1'b0;
        check("flushed mtlo lo", mif.lo, 32'h1234);
        mif.mthi  = 1'b1;
        mif.wdata = 32'hCAFE_F00D;
        step();
        mif.mthi   = 1'b0;
        mif.rd_sel = 1'b1;
        #1;
        check("mthi hi", mif.hi, 32'hCAFE_F00D);
        check("mfhi rd_data", mif.rd_data, 32'hCAFE_F00D);
        mif.rd_sel = 1'b0;

        // Directed operations.
        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu 7/2", 2'b11, 32'd7, 32'd2);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu 5/0", 2'b11, 32'd5, 32'd0);
        run_op("div 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9);
        run_op("mult min*-1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            run_op("random op", rop, ra, rb);
        end

        // MULT 6*7 with MFLO from cycle 5. A flushed cycle 15 must not stall.
        sb_q.push_back(model(2'b00, 32'd6, 32'd7));
        mif.start = 1'b1;
        mif.op    = 2'b00;
        mif.src_a = 32'd6;
        mif.src_b = 32'd7;
        step();
        mif.start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            mif.rd_req   = (c >= 5);
            mif.flush_ex = (c == 15);
            #1;
            if (c == 15) begin
                check("stall under flush", mif.stall, 0);
            end else if (mif.stall !== (c >= 5)) begin
                bad++;
            end
            step();
        end
        mif.flush_ex = 1'b0;
        #1;
        check("mflo stall cycles 1-33", bad, 0);
        check("mflo stall cycle 34", mif.stall, 0);
        check("mflo rd_data cycle 34", mif.rd_data, 32'h2A);
        check_result("mult 6*7", 33);
        mif.rd_req = 1'b0;

        // MULT 6*7 followed by a second start from cycle 10. It is accepted at E34.
        sb_q.push_back(model(2'b00, 32'd6, 32'd7));
        mif.start = 1'b1;
        mif.op    = 2'b00;
        mif.src_a = 32'd6;
        mif.src_b = 32'd7;
        step();
        mif.start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c >= 10) begin
                mif.start = 1'b1;
                mif.op    = 2'b01;
                mif.src_a = 32'd2;
                mif.src_b = 32'd3;
            end
            #1;
            if (mif.stall !== (c >= 10)) begin
                bad++;
            end
            step();
        end
        #1;
        check("start stall cycles 1-33", bad, 0);
        check("start stall cycle 34", mif.stall, 0);
        check_result("first mult 6*7", 33);
        sb_q.push_back(model(2'b01, 32'd2, 32'd3));
        step();
        mif.start = 1'b0;
        wait_done("back-to-back multu 2*3");

        // Reset at cycle 10 of a DIV discards it; the next op runs normally.
        sb_q.push_back(model(2'b10, 32'hFFFF_FF9C, 32'd7));
        mif.start = 1'b1;
        mif.op    = 2'b10;
        mif.src_a = 32'hFFFF_FF9C;
        mif.src_b = 32'd7;
        step();
        mif.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            step();
        end
        mif.rd_req = 1'b1;
        rst_n      = 1'b0;
        #1;
        check("mid-op reset busy", mif.busy, 0);
        check("mid-op reset stall", mif.stall, 0);
        check("mid-op reset hi", mif.hi, 0);
        check("mid-op reset lo", mif.lo, 0);
        void'(sb_q.pop_front());
        mif.rd_req = 1'b0;
        #3 rst_n = 1'b1;
        step();
        run_op("post-reset div 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9);

        check("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
